uart_tx_port: RTL and testbench

UART_TX_PORT -- requirements
Module: uart_tx_port

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_fifo.sv | 62 ++++++
 rtl/uart_tx_port.sv | 156 +++++++++++++++
 tb/tb_uart_tx_port.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit port.
//   tx_state_t      - transmitter FSM states (IDLE/START/DATA/STOP)
//   STAT_*          - bit positions inside the 8-bit status word
//                     {4'b0, busy, overflow, full, empty}
//   BAUD_W          - width of the baud counter (covers CLKS_PER_BIT up to 65535)
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_OVF   = 2;
  localparam int STAT_BUSY  = 3;

  localparam int BAUD_W = 16;

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: small synchronous FIFO holding bytes waiting to be transmitted.
// Ports:
//   clk, reset (async, active-high)
//   push, wdata  - store request; accepted when not full, or when a pop
//                  happens on the same edge
//   pop          - remove the head entry (ignored when empty)
//   rdata        - head entry, valid whenever empty=0
//   count        - number of stored entries (0..DEPTH)
//   full, empty  - decoded from the registered count
module uart_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a byte when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // NOTE: the storage array has no reset; only pointers and count define
  // which entries are valid, so resetting the array would buy nothing.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_port.sv
// uart_tx_port: memory-mapped UART transmitter with a byte FIFO.
// Ports:
//   clk, reset (async, active-high)
//   we       - store strobe from the address decode
//   wdata    - byte to queue for transmission
//   ovf_clr  - clears the sticky overflow flag (a same-edge overflow wins)
//   tx       - registered serial output, idle high, 8N1, LSB first
//   status   - {4'b0, busy, overflow, full, empty}
// Parameters:
//   CLKS_PER_BIT - clk cycles per serial bit (2..65535)
//   FIFO_DEPTH   - FIFO entries, power of two (2..16)
module uart_tx_port
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [7:0] wdata,
  input  logic       ovf_clr,
  output logic       tx,
  output logic [7:0] status
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  tx_state_t         state, state_next;
  logic [BAUD_W-1:0] baud_cnt, baud_next;
  logic [2:0]        bit_idx, bit_next;
  logic [7:0]        shreg, sh_next;
  logic              tx_next;
  logic              pop;
  logic              busy;
  logic              overflow;
  logic              ovf_event;
  logic              baud_end;
  logic              has_data;
  logic [7:0]        fifo_rdata;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full;
  logic              fifo_empty;

  uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (we),
    .pop   (pop),
    .wdata (wdata),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign has_data  = (fifo_count != '0);
  assign baud_end  = (baud_cnt == BAUD_LAST);
  // A write is lost only when the FIFO is full and nothing leaves this edge.
  assign ovf_event = we && fifo_full && !pop;

  // State register. tx is registered here so no path exists from we/wdata.
  // NOTE: sequential blocks use non-blocking assignments only, so every
  // register samples the values computed before this edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_idx  <= bit_next;
      shreg    <= sh_next;
      tx       <= tx_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          overflow <= 1'b0;
    else if (ovf_event) overflow <= 1'b1;
    else if (ovf_clr)   overflow <= 1'b0;
  end

  // Next-state logic. The baud counter restarts on every state or bit change.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    state_next = state;
    baud_next  = baud_cnt + 1'b1;
    bit_next   = bit_idx;
    sh_next    = shreg;
    pop        = 1'b0;
    unique case (state)
      IDLE: begin
        baud_next = '0;
        if (has_data) begin
          pop        = 1'b1;
          sh_next    = fifo_rdata;
          state_next = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_next  = '0;
          state_next = DATA;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_next = '0;
          // 3-bit index wraps 7->0 as the last bit hands over to STOP.
          bit_next  = bit_idx + 1'b1;
          if (bit_idx == 3'd7) state_next = STOP;
          else                 sh_next    = {1'b0, shreg[7:1]};
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_next = '0;
          // Chain straight into the next frame when a byte is waiting.
          if (has_data) begin
            pop        = 1'b1;
            sh_next    = fifo_rdata;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic: tx follows the state being entered, so it changes on the
  // same edge as the state; busy and status decode the registered state.
  always_comb begin
    unique case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = sh_next[0];
      default: tx_next = 1'b1;
    endcase
    busy               = (state != IDLE);
    status             = '0;
    status[STAT_EMPTY] = fifo_empty;
    status[STAT_FULL]  = fifo_full;
    status[STAT_OVF]   = overflow;
    status[STAT_BUSY]  = busy;
  end

endmodule

// File: tb/tb_uart_tx_port.sv
// tb_uart_tx_port: self-checking bench for uart_tx_port with
// CLKS_PER_BIT=4 and FIFO_DEPTH=4. Inputs change 1 ns after the rising
// edge; outputs are sampled at that same point.
module tb_uart_tx_port;
  import uart_pkg::*;

  logic       clk;
  logic       reset;
  logic       we;
  logic [7:0] wdata;
  logic       ovf_clr;
  logic       tx;
  logic [7:0] status;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_port #(
    .CLKS_PER_BIT (4),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .we      (we),
    .wdata   (wdata),
    .ovf_clr (ovf_clr),
    .tx      (tx),
    .status  (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;   // bit i = tx level during bit period i
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] frame_of(input logic [7:0] d);
    return {1'b1, d, 1'b0};
  endfunction

  // Called right after the edge that starts a frame; walks its 40 cycles
  // and leaves the bench just after the edge that ends it.
  task automatic check_frame(input logic [9:0] fexp, input string name);
    logic [9:0] got;
    int bad;
    int idle;
    got  = '0;
    bad  = 0;
    idle = 0;
    for (int c = 0; c < 40; c++) begin
      if (c % 4 == 1) got[c/4] = tx;
      if (tx !== fexp[c/4]) bad++;
      if (status[3] !== 1'b1) idle++;
      step();
      we = 1'b0;
    end
    check({name, " bits"}, 32'(got), 32'(fexp));
    check({name, " bit width"}, 32'(bad), 32'd0);
    check({name, " busy"}, 32'(idle), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{data: 8'hA5, frame: 10'b1_1010_0101_0};
    vecs[1] = '{data: 8'h00, frame: 10'b1_0000_0000_0};
    vecs[2] = '{data: 8'hFF, frame: 10'b1_1111_1111_0};
    vecs[3] = '{data: 8'h3C, frame: 10'b1_0011_1100_0};

    reset   = 1'b1;
    we      = 1'b0;
    wdata   = 8'h00;
    ovf_clr = 1'b0;
    repeat (3) step();
    check("reset tx", 32'(tx), 32'd1);
    check("reset status", 32'(status), 32'h01);
    reset = 1'b0;
    step();
    check("idle status", 32'(status), 32'h01);

    // Single frames: stored at edge N, popped and tx low at edge N+1.
    for (int i = 0; i < 4; i++) begin
      we    = 1'b1;
      wdata = vecs[i].data;
      step();
      we = 1'b0;
      check($sformatf("vec%0d stored status", i), 32'(status), 32'h00);
      check($sformatf("vec%0d stored tx", i), 32'(tx), 32'd1);
      step();
      check($sformatf("vec%0d popped status", i), 32'(status), 32'h09);
      check_frame(vecs[i].frame, $sformatf("vec%0d frame", i));
      check($sformatf("vec%0d done status", i), 32'(status), 32'h01);
      check($sformatf("vec%0d done tx", i), 32'(tx), 32'd1);
    end

    // Three consecutive writes -> three back-to-back frames.
    we    = 1'b1;
    wdata = 8'h01;
    step();
    wdata = 8'h02;
    step();
    wdata = 8'h03;
    check_frame(frame_of(8'h01), "b2b frame1");
    check("b2b after pop2 status", 32'(status), 32'h08);
    check_frame(frame_of(8'h02), "b2b frame2");
    check("b2b after pop3 status", 32'(status), 32'h09);
    check_frame(frame_of(8'h03), "b2b frame3");
    check("b2b done status", 32'(status), 32'h01);

    // Fill while busy, overflow, clear, set-wins, then write on the pop edge.
    we    = 1'b1;
    wdata = 8'h11;
    step();
    we = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      logic [7:0] b;
      b     = 8'h21 << k;
      if (k == 3) b = 8'h18;
      we    = 1'b1;
      wdata = b;
      step();
      check($sformatf("fill write%0d status", k + 1), 32'(status), (k == 3) ? 32'h0A : 32'h08);
    end
    wdata = 8'h99;
    step();
    check("overflow write status", 32'(status), 32'h0E);
    we      = 1'b0;
    ovf_clr = 1'b1;
    step();
    check("ovf_clr status", 32'(status), 32'h0A);
    we = 1'b1;
    step();
    check("ovf_clr with overflow status", 32'(status), 32'h0E);
    we = 1'b0;
    step();
    check("ovf_clr again status", 32'(status), 32'h0A);
    ovf_clr = 1'b0;
    for (int c = 8; c < 39; c++) step();
    check("last stop cycle tx", 32'(tx), 32'd1);
    check("last stop cycle status", 32'(status), 32'h0A);
    we    = 1'b1;
    wdata = 8'h25;
    step();
    we = 1'b0;
    check("write on pop edge status", 32'(status), 32'h0A);
    check("write on pop edge tx", 32'(tx), 32'd0);
    check_frame(frame_of(8'h21), "queued frame1");
    check_frame(frame_of(8'h42), "queued frame2");
    check_frame(frame_of(8'h84), "queued frame3");
    check_frame(frame_of(8'h18), "queued frame4");
    check_frame(frame_of(8'h25), "queued frame5");
    check("queue drained status", 32'(status), 32'h01);

    // Reset during DATA bit 3 with two bytes queued.
    we    = 1'b1;
    wdata = 8'hA5;
    step();
    wdata = 8'h11;
    step();
    wdata = 8'h22;
    step();
    we = 1'b0;
    for (int c = 1; c < 17; c++) step();
    check("pre-reset bit3 tx", 32'(tx), 32'd0);
    check("pre-reset status", 32'(status), 32'h08);
    #2;
    reset = 1'b1;
    #1;
    check("mid-frame reset tx", 32'(tx), 32'd1);
    check("mid-frame reset status", 32'(status), 32'h01);
    step();
    reset = 1'b0;
    begin
      int bad;
      bad = 0;
      for (int c = 0; c < 20; c++) begin
        if (tx !== 1'b1 || status !== 8'h01) bad++;
        step();
      end
      check("no frame after reset", 32'(bad), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
